// File: rtl/keypad_emulator.sv
// Emulates a 4x4 matrix keypad toward a column-scanning decoder, pressing commanded keys for timed holds.
// Optional contact bounce on press/release edges is enabled with `define KEYPAD_EMU_BOUNCE_EN.
module keypad_emulator #(
   parameter int clk_freq      = 50_000_000,
   parameter int tick_cycles   = clk_freq / 1000,
   parameter int release_ms    = 20,
   parameter int bounce_cycles = 1000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [3:0]  col,
   output logic [3:0]  row,
   input  logic        cmd_valid,
   input  logic [3:0]  cmd_key,
   input  logic [7:0]  cmd_hold,
   output logic        cmd_ready,
   input  logic        abort,
   output logic        busy,
   output logic        done,
   output logic [15:0] key_mask
);
   localparam int TW = (tick_cycles > 1) ? $clog2(tick_cycles) : 1;
   localparam int MW = 16;

   typedef enum logic [1:0] {IDLE = 2'd0, PRESS = 2'd1, GAP = 2'd2} state_t;

   state_t        state_r, state_nx;
   logic [TW-1:0] tick_cnt_r, tick_nx;
   logic [MW-1:0] ms_cnt_r, ms_nx;
   logic [15:0]   mask_nx;
   logic          tick_wrap, last_tick;
   logic [3:0]    col_meta_r, col_s;
   logic [15:0]   eff_s, eff_d1_r, eff_d2_r;

   // Row bit r goes low when any low column has its mapped key pressed.
   function automatic logic [3:0] row_of(input logic [3:0] cs, input logic [15:0] k);
      logic [3:0] low;
      low = ({4{~cs[3]}} & {k[1],  k[4],  k[7],  k[0]})
          | ({4{~cs[2]}} & {k[2],  k[5],  k[8],  k[15]})
          | ({4{~cs[1]}} & {k[3],  k[6],  k[9],  k[14]})
          | ({4{~cs[0]}} & {k[10], k[11], k[12], k[13]});
      return ~low;
   endfunction

   assign tick_wrap = (tick_cnt_r == TW'(tick_cycles - 1));
   assign last_tick = tick_wrap && (ms_cnt_r == MW'(1));
   assign cmd_ready = (state_r == IDLE);
   assign busy      = (state_r != IDLE);
   assign done      = (state_r == GAP) && last_tick;

   // Next-state and counter logic for the press/gap sequencer.
   always_comb begin
      state_nx = state_r;
      tick_nx  = tick_cnt_r;
      ms_nx    = ms_cnt_r;
      mask_nx  = key_mask;
      case (state_r)
         IDLE: begin
            tick_nx = '0;
            if (cmd_valid) begin
               state_nx = PRESS;
               mask_nx  = 16'd1 << cmd_key;
               ms_nx    = (cmd_hold == 8'd0) ? MW'(1) : MW'(cmd_hold);
            end else begin
               state_nx = IDLE;
            end
         end
         PRESS: begin
            if (abort || last_tick) begin
               state_nx = GAP;
               mask_nx  = 16'd0;
               ms_nx    = MW'(release_ms);
               tick_nx  = '0;
            end else begin
               tick_nx = tick_wrap ? '0 : tick_cnt_r + TW'(1);
               ms_nx   = tick_wrap ? ms_cnt_r - MW'(1) : ms_cnt_r;
            end
         end
         GAP: begin
            if (last_tick) begin
               state_nx = IDLE;
               ms_nx    = '0;
               tick_nx  = '0;
            end else begin
               tick_nx = tick_wrap ? '0 : tick_cnt_r + TW'(1);
               ms_nx   = tick_wrap ? ms_cnt_r - MW'(1) : ms_cnt_r;
            end
         end
         default: begin
            state_nx = IDLE;
            mask_nx  = 16'd0;
            ms_nx    = '0;
            tick_nx  = '0;
         end
      endcase
   end

   // Sequencer state register; reset releases the key at once.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r    <= IDLE;
         tick_cnt_r <= '0;
         ms_cnt_r   <= '0;
         key_mask   <= 16'd0;
      end else begin
         state_r    <= state_nx;
         tick_cnt_r <= tick_nx;
         ms_cnt_r   <= ms_nx;
         key_mask   <= mask_nx;
      end
   end

   // Key state is delayed two cycles to match the column synchronizer, so row follows both by 3 cycles.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         col_meta_r <= 4'hF;
         col_s      <= 4'hF;
         eff_d1_r   <= 16'd0;
         eff_d2_r   <= 16'd0;
         row        <= 4'hF;
      end else begin
         col_meta_r <= col;
         col_s      <= col_meta_r;
         eff_d1_r   <= eff_s;
         eff_d2_r   <= eff_d1_r;
         row        <= row_of(col_s, eff_d2_r);
      end
   end

`ifdef KEYPAD_EMU_BOUNCE_EN
   localparam int BW = $clog2(bounce_cycles + 1);

   logic [7:0]    lfsr_r;
   logic [BW-1:0] phase_r;
   logic [3:0]    key_r;
   logic          in_window;

   // LFSR x^8+x^6+x^5+x^4+1, cycles-into-phase counter, and the key held across PRESS and GAP.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         lfsr_r  <= 8'hA5;
         phase_r <= '0;
         key_r   <= 4'd0;
      end else begin
         lfsr_r <= {lfsr_r[6:0], lfsr_r[7] ^ lfsr_r[5] ^ lfsr_r[4] ^ lfsr_r[3]};
         if (state_nx != state_r) begin
            phase_r <= '0;
         end else if (phase_r != BW'(bounce_cycles)) begin
            phase_r <= phase_r + BW'(1);
         end else begin
            phase_r <= phase_r;
         end
         if (cmd_ready && cmd_valid) begin
            key_r <= cmd_key;
         end else begin
            key_r <= key_r;
         end
      end
   end

   assign in_window = (state_r != IDLE) && (phase_r < BW'(bounce_cycles));
   assign eff_s     = in_window ? (lfsr_r[0] ? (16'd1 << key_r) : 16'd0) : key_mask;
`else
   // Bounce window length has no effect in the clean build.
   localparam int unused_bounce_cycles = bounce_cycles;
   assign eff_s = key_mask;
`endif

endmodule

// File: doc/keypad_emulator.md
# keypad_emulator

Drives the row lines of the 4x4 matrix keypad interface in response to column scan strobes, so that it behaves as a physical keypad to the team's column-scanning keypad decoder. Test and loopback logic uses it to issue timed key presses through a valid/ready command port. It is used for on-board self-test of the guessing game, and can also be wired to an off-chip PMOD so that a second FPGA can be driven. Each press is held for a commanded number of milliseconds, followed by a fixed release gap.

## Interface
Parameters:
- clk_freq, 50_000_000: clock frequency in Hz; used only for the tick_cycles default.
- tick_cycles, clk_freq/1000: cycles per "ms" tick. Benches shrink this value.
- release_ms, 20: release gap in ticks. Must be ≥1.
- bounce_cycles, 1000: bounce window length in cycles. Used only when KEYPAD_EMU_BOUNCE_EN is defined.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-high reset.
- col  in  4  column strobes from the scanner. Active low; may be asynchronous.
- row  out  4  row lines to the scanner. Active low.
- cmd_valid  in  1  press command valid.
- cmd_key  in  4  key code 0..15.
- cmd_hold  in  8  hold time in ticks. A value of 0 is treated as 1.
- cmd_ready  out  1  high exactly when the state is IDLE.
- abort  in  1  synchronous; ends the current press early.
- busy  out  1  high in PRESS or GAP.
- done  out  1  one-cycle pulse at the end of GAP.
- key_mask  out  16  one-hot mask of the key currently pressed (clean, before any bounce).

## Operation
- States are IDLE, PRESS and GAP. The reset state is IDLE.
- **IDLE:** when cmd_valid && cmd_ready:
  - key_mask <= 1<<cmd_key
  - ms_cnt <= max(cmd_hold,1)
  - tick_cnt <= 0
  - next state is PRESS
- **PRESS:**
  - tick_cnt counts 0..tick_cycles-1, then wraps. Each wrap decrements ms_cnt.
  - When ms_cnt would reach 0: key_mask <= 0, ms_cnt <= release_ms, next state is GAP.
  - abort=1 causes the same transition on the same edge.
- **GAP:** counts the same way. On reaching 0: next state is IDLE and done=1 for that one cycle.
- cmd_valid is ignored outside IDLE. Commands are never queued.
- The command is captured on the accepting edge, so cmd_key and cmd_hold may change afterwards.
- Column synchronisation: col passes through a 2-flop synchronizer to give col_s.
- Key map (row bit that goes low for a given low column):
  - col_s[3]: row[3]=key1, row[2]=key4, row[1]=key7, row[0]=key0
  - col_s[2]: row[3]=key2, row[2]=key5, row[1]=key8, row[0]=key15
  - col_s[1]: row[3]=key3, row[2]=key6, row[1]=key9, row[0]=key14
  - col_s[0]: row[3]=key10, row[2]=key11, row[1]=key12, row[0]=key13
- Row computation:
  - row[r] is low if any low column has its mapped key pressed. Multiple low columns are ORed.
  - col_s=4'b1111 gives row=4'b1111.
  - row is registered.
- Reset values: row=4'hF, key_mask=0, busy=0, done=0, cmd_ready=1, all counters 0, state IDLE.
- A reset asserted mid-press releases the key immediately (asynchronously). The in-flight command is lost and done is not pulsed.

## Timing
- Latency from col to row is 3 cycles: 2 for synchronisation and 1 for the output register. This fits inside the decoder's 16-cycle column dwell.
- Press duration: key_mask is nonzero for exactly max(cmd_hold,1)*tick_cycles cycles. It starts on the cycle after acceptance.
- Gap duration: release_ms*tick_cycles cycles. done is asserted in the final GAP cycle.
- cmd_ready rises on the cycle after done.
- Minimum command-to-command period: (max(cmd_hold,1)+release_ms)*tick_cycles+1 cycles.
- abort in PRESS: key_mask is 0 from the next cycle and the gap runs in full. abort in IDLE or GAP has no effect.
- If abort occurs on the same edge as a natural hold expiry, there is a single transition to GAP.

## Configuration
- The macro is KEYPAD_EMU_BOUNCE_EN.
- **When defined:**
  - An 8-bit LFSR (x^8+x^6+x^5+x^4+1, seed 8'hA5, reloaded on reset) advances every cycle.
  - For the first bounce_cycles cycles of PRESS, and the first bounce_cycles cycles of GAP, the key's effective pressed bit equals lfsr[0].
  - Outside those windows the effective state is clean.
  - key_mask always reports the clean state.
- **When undefined:** press and release edges are clean. The LFSR and the bounce_cycles logic are absent.

## Test plan
- **Reset values:** assert rst mid-cycle -> row=4'hF, cmd_ready=1, busy=0 asynchronously. After deassertion, col=4'b1011 -> row stays 4'hF.
- **Single press** (tick_cycles=10, release_ms=2): send cmd_key=5, cmd_hold=3. Hold col=4'b1011 -> row=4'b1011 for 30 cycles, starting 3 cycles after key_mask changes. With col=4'b0111 -> row=4'hF. done pulses 20 cycles after release.
- **Zero hold:** send cmd_hold=0 with key 13 -> key_mask=16'h2000 for exactly 10 cycles. With col=4'b1110 -> row=4'b1110.
- **Handshake:** pulse cmd_valid with key 2 while busy -> ignored, and key_mask never shows bit 2. Then send back-to-back commands at cmd_ready -> both are executed in order.
- **Abort and reset:** abort on cycle 5 of a 50-cycle press -> key_mask=0 on the next cycle and the gap completes. Reset at cycle 5 of a press -> row=4'hF immediately and no done pulse.
- **Loopback with the keypad decoder:** send keys 0, 9, 15, each with cmd_hold=20 -> the decoder's keys output shows only the matching bit after its debounce. With KEYPAD_EMU_BOUNCE_EN defined, there is still exactly one clean assertion per press.
